keypad_event_scanner: RTL and testbench

Parametrised matrix-keypad scanner with an internal scan prescaler, frame-level debounce and a key-event FIFO with a valid/ready interface. It replaces the fixed 4x4 scanner that runs on a separately divided clock. It runs directly on the 50 MHz system clock and drives the keypad columns. It delivers one debounced press event per key, which the calculator datapath and display logic consume.

---
 rtl/keypad_event_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_event_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner running on the system clock: column prescaler,
// frame-level debounce and a first-word-fall-through key-event FIFO.

// Generic first-word-fall-through FIFO.
// Latency: a write is visible at the head the next cycle; a pop is reflected the next cycle.
// Backpressure: wr_rdy drops only when full and no pop is taken in the same cycle.
module kes_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  output logic [W-1:0]           rd_dat,
  input  logic                   rd_rdy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy = (count != (AW+1)'(DEPTH)) || pop;
  assign push   = wr_vld && wr_rdy;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// Keypad scanner: one press event per newly debounced key, lowest code first.
// Latency: event at the FIFO head two cycles after the accepting last-column tick.
// Backpressure: key_ready pops the head; events arriving at a full FIFO are dropped and flagged.
module keypad_event_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_W      = $clog2(ROWS*COLS)
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [ROWS-1:0]             row,
  output logic [COLS-1:0]             col,
  output logic [KEY_W-1:0]            key_code,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic                        keypressed,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int NK = ROWS * COLS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [CW-1:0]    col_idx;
  logic [NK-1:0]    raw_map;
  logic [NK-1:0]    prev_map;
  logic [NK-1:0]    deb_map;
  logic [NK-1:0]    new_map;
  logic             frame_end;
  logic [SW-1:0]    stable_cnt;
  logic [SW-1:0]    stable_nxt;
  logic             accept;
  logic             push_vld;
  logic             push_rdy;
  logic [KEY_W-1:0] push_dat;

  assign tick = (presc == PRESC_LAST);
  assign col  = ~(COLS'(1) << col_idx);

  // Rows are sampled at the end of each column's dwell, giving them SCAN_DIV cycles to settle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc     <= '0;
      col_idx   <= '0;
      raw_map   <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= tick && (col_idx == COL_LAST);
      if (tick) begin
        presc   <= '0;
        col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
        for (int k = 0; k < NK; k++) begin
          if (CW'(k % COLS) == col_idx) raw_map[k] <= ~row[k / COLS];
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_comb begin
    stable_nxt = stable_cnt;
    if (raw_map != prev_map)         stable_nxt = '0;
    else if (stable_cnt != STABLE_MAX) stable_nxt = stable_cnt + SW'(1);
  end

  assign accept   = frame_end && (stable_nxt == STABLE_MAX) && (raw_map != deb_map);
  assign new_map  = raw_map & ~deb_map;
  assign push_vld = accept && (new_map != '0);

  // Simultaneous new presses collapse to the lowest key code.
  always_comb begin
    push_dat = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (new_map[k]) push_dat = KEY_W'(k);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_map   <= '0;
      stable_cnt <= '0;
      deb_map    <= '0;
      keypressed <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (frame_end) begin
        prev_map   <= raw_map;
        stable_cnt <= stable_nxt;
      end
      if (accept) begin
        deb_map    <= raw_map;
        keypressed <= |raw_map;
      end
      if (push_vld && !push_rdy) overflow <= 1'b1;
    end
  end

  kes_fifo #(
    .W     (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_vld (key_valid),
    .rd_dat (key_code),
    .rd_rdy (key_ready),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: keypad matrix model, frame-level reference model and directed scenarios.
module tb_keypad_event_scanner;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int NK         = ROWS * COLS;

  logic          clock = 1'b0;
  logic          resetn;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ready;
  logic          keypressed;
  logic          overflow;
  logic [2:0]    fifo_count;
  logic [NK-1:0] keys;

  int n_cmp  = 0;
  int n_fail = 0;

  keypad_event_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keypressed (keypressed),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col[c] && keys[r*COLS+c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NK-1:0] m);
    for (int i = 0; i < NK; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Reference model: frames as whole key sets, a short history of frames, and a queue of codes.
  int            cyc;
  int            q[$];
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_raw;
  logic [NK-1:0] m_deb;
  logic          m_ovf;
  bit            pend_vld;
  logic [NK-1:0] pend_frame;
  int            pend_code;
  int            mcol;
  bit            same;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cyc = 0;
      q.delete();
      hist.delete();
      hist.push_back('0);
      m_raw = '0;
      m_deb = '0;
      m_ovf = 1'b0;
      pend_vld = 0;
      pend_code = -1;
    end else begin
      if (key_ready && q.size() > 0) void'(q.pop_front());
      if (pend_vld) begin
        m_deb = pend_frame;
        if (pend_code >= 0) begin
          if (q.size() < FIFO_DEPTH) q.push_back(pend_code);
          else m_ovf = 1'b1;
        end
        pend_vld = 0;
      end
      if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
        mcol = (cyc / SCAN_DIV) % COLS;
        for (int r = 0; r < ROWS; r++) m_raw[r*COLS+mcol] = keys[r*COLS+mcol];
        if (mcol == COLS - 1) begin
          hist.push_back(m_raw);
          if (hist.size() > DEBOUNCE) void'(hist.pop_front());
          same = 1;
          foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
          if (hist.size() == DEBOUNCE && same && m_raw != m_deb) begin
            pend_vld   = 1;
            pend_frame = m_raw;
            pend_code  = lowest(m_raw & ~m_deb);
          end
        end
      end
      cyc++;
    end
  end

  logic [COLS-1:0] e_col;
  always @(negedge clock) begin
    e_col = ~(4'b0001 << ((cyc / SCAN_DIV) % COLS));
    check("col", col, e_col);
    check("key_valid", key_valid, q.size() != 0);
    if (q.size() != 0) check("key_code", key_code, q[0]);
    check("keypressed", keypressed, |m_deb);
    check("overflow", overflow, m_ovf);
    check("fifo_count", fifo_count, q.size());
  end

  task automatic at_cycle(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != n) check("cycle_wait", cyc, n);
  endtask

  int ovf_codes[5]   = '{1, 4, 7, 10, 13};
  int drain_a[4]     = '{1, 4, 7, 10};
  int drain_b[4]     = '{5, 11, 14, 15};

  initial begin
    resetn    = 1'b1;
    keys      = '0;
    key_ready = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_pressed", keypressed, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", fifo_count, 0);
    #2 resetn = 1'b1;

    // Column walk after reset release.
    at_cycle(3);  check("col_c3", col, 4'b1110);
    at_cycle(4);  check("col_c4", col, 4'b1101);
    at_cycle(8);  check("col_c8", col, 4'b1011);
    at_cycle(12); check("col_c12", col, 4'b0111);
    at_cycle(16); check("col_c16", col, 4'b1110);

    // Single press of r1,c2 from the start of frame 1.
    keys[6] = 1'b1;
    at_cycle(64); check("press_early", key_valid, 0);
    at_cycle(65);
    check("press_valid", key_valid, 1);
    check("press_code", key_code, 6);
    check("press_level", keypressed, 1);
    check("press_count", fifo_count, 1);
    at_cycle(70); key_ready = 1'b1;
    at_cycle(71); key_ready = 1'b0;
    check("pop_count", fifo_count, 0);
    check("pop_valid", key_valid, 0);
    at_cycle(96); keys = '0;
    check("held_no_event", fifo_count, 0);
    at_cycle(144); check("release_early", keypressed, 1);
    keys[0] = 1'b1;
    at_cycle(145);
    check("release_level", keypressed, 0);
    check("release_no_event", key_valid, 0);

    // Key 0 toggling every frame must never be accepted.
    for (int k = 10; k <= 18; k++) begin
      at_cycle(16 * k);
      keys[0] = (k % 2 == 1);
      check("bounce_valid", key_valid, 0);
      check("bounce_level", keypressed, 0);
    end
    at_cycle(304); keys = '0;
    at_cycle(336);
    check("bounce_end_valid", key_valid, 0);
    check("bounce_end_level", keypressed, 0);

    // Five sequential presses into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      at_cycle(336 + 48 * i);
      keys = '0;
      keys[ovf_codes[i]] = 1'b1;
    end
    at_cycle(529); check("fill_count", fifo_count, 4);
    at_cycle(576); check("ovf_before", overflow, 0);
    keys = '0;
    at_cycle(577);
    check("ovf_set", overflow, 1);
    check("ovf_count", fifo_count, 4);
    at_cycle(580); key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_cycle(580 + i);
      check("drain_a_code", key_code, drain_a[i]);
    end
    at_cycle(584); key_ready = 1'b0;
    check("drain_a_count", fifo_count, 0);
    check("drain_a_valid", key_valid, 0);

    // Keys 3 and 9 together, then build up to a full FIFO and push/pop on the same edge.
    at_cycle(624); keys = '0; keys[3] = 1'b1; keys[9] = 1'b1;
    at_cycle(672); check("simul_early", key_valid, 0);
    keys[5] = 1'b1;
    at_cycle(673);
    check("simul_count", fifo_count, 1);
    check("simul_code", key_code, 3);
    at_cycle(720); check("simul_single", fifo_count, 1);
    keys[11] = 1'b1;
    at_cycle(768); keys[14] = 1'b1;
    at_cycle(816); keys[15] = 1'b1;
    at_cycle(817); check("full_count", fifo_count, 4);
    at_cycle(864);
    check("pp_before_count", fifo_count, 4);
    check("pp_before_code", key_code, 3);
    key_ready = 1'b1;
    at_cycle(865); key_ready = 1'b0;
    check("pp_after_count", fifo_count, 4);
    check("pp_after_code", key_code, 5);
    at_cycle(870); key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_cycle(870 + i);
      check("drain_b_code", key_code, drain_b[i]);
    end
    at_cycle(874); key_ready = 1'b0;
    check("drain_b_count", fifo_count, 0);

    // Mid-operation reset with two queued events and a partial debounce.
    at_cycle(880); keys = '0;
    at_cycle(928); keys[2] = 1'b1;
    at_cycle(976); keys[8] = 1'b1;
    at_cycle(977); check("pre_rst_code", key_code, 2);
    at_cycle(1024); keys[12] = 1'b1;
    at_cycle(1060); check("pre_rst_count", fifo_count, 2);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_level", keypressed, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_count", fifo_count, 0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
    at_cycle(48); check("rereport_early", key_valid, 0);
    at_cycle(49);
    check("rereport_valid", key_valid, 1);
    check("rereport_code", key_code, 2);
    check("rereport_level", keypressed, 1);
    check("rereport_count", fifo_count, 1);
    keys = '0;
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
